// File: rtl/msrr8_cmd_sequencer.sv
// Command sequencer for the 8-bit multi-mode shift/rotate register: turns one
// LOAD/ROTATE/FILL/NOP command into the per-cycle mode/sIn sequence, then pulses done.
module msrr8_cmd_sequencer #(
  parameter int W = 8
) (
  input  logic                   clk,
  input  logic                   Re,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [W-1:0]           cmd_data,
  input  logic [$clog2(W)-1:0]   cmd_cnt,
  output logic [1:0]             mode,
  output logic                   sIn,
  output logic                   busy,
  output logic                   done
);

  localparam int CW = $clog2(W) + 1;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_ROT  = 2'b10;

  localparam logic [1:0] M_HOLD  = 2'b00;
  localparam logic [1:0] M_SHIFT = 2'b01;
  localparam logic [1:0] M_ROT   = 2'b10;
  localparam logic [1:0] M_DBL   = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ROT, S_FILL, S_DONE} state_t;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [W-1:0]   r_data;
  logic           r_fill;
  logic [1:0]     r_mode;
  logic           r_sin;
  logic           r_busy;
  logic           r_done;
  logic           r_ready;
  logic           w_accept;
  logic           w_last;

  assign w_accept  = cmd_valid & r_ready;
  assign w_last    = (r_cnt == CW'(1));
  // Re gates ready so the handshake is closed for the whole time reset is held.
  assign cmd_ready = r_ready & Re;
  assign mode      = r_mode;
  assign sIn       = r_sin;
  assign busy      = r_busy;
  assign done      = r_done;

  always_ff @(posedge clk or negedge Re) begin
    if (!Re) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_data  <= '0;
      r_fill  <= 1'b0;
      r_mode  <= M_HOLD;
      r_sin   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
            r_data  <= cmd_data;
            r_fill  <= cmd_data[0];
            case (cmd_op)
              OP_NOP: begin
                r_state <= S_DONE;
                r_mode  <= M_HOLD;
                r_sin   <= 1'b0;
                r_done  <= 1'b1;
              end
              OP_LOAD: begin
                r_state <= S_LOAD;
                r_cnt   <= CW'(W);
                r_mode  <= M_SHIFT;
                r_sin   <= cmd_data[0];
              end
              OP_ROT: begin
                r_state <= S_ROT;
                r_cnt   <= (cmd_cnt == '0) ? CW'(W) : {1'b0, cmd_cnt};
                r_mode  <= M_ROT;
                r_sin   <= 1'b0;
              end
              default: begin
                r_state <= S_FILL;
                r_cnt   <= CW'(W / 2);
                r_mode  <= M_DBL;
                r_sin   <= cmd_data[0];
              end
            endcase
          end
        end
        S_LOAD, S_ROT, S_FILL: begin
          if (w_last) begin
            r_state <= S_DONE;
            r_cnt   <= '0;
            r_mode  <= M_HOLD;
            r_sin   <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt  <= r_cnt - 1'b1;
            r_data <= r_data >> 1;
            // Next serial bit is looked ahead from the shift register so sIn stays registered.
            if (r_state == S_LOAD)
              r_sin <= r_data[1];
            else if (r_state == S_FILL)
              r_sin <= r_fill;
            else
              r_sin <= 1'b0;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_mode  <= M_HOLD;
          r_sin   <= 1'b0;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msrr8_cmd_sequencer.sv
// Bench for msrr8_cmd_sequencer: queue-based reference of expected per-cycle outputs,
// a downstream shift/rotate register, and directed commands with literal checks.
module tb_msrr8_cmd_sequencer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         Re = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = 2'b00;
  logic [W-1:0] cmd_data = '0;
  logic [2:0]   cmd_cnt = '0;
  logic [1:0]   mode;
  logic         sIn;
  logic         busy;
  logic         done;

  msrr8_cmd_sequencer #(.W(W)) dut (
    .clk(clk), .Re(Re), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_cnt(cmd_cnt),
    .mode(mode), .sIn(sIn), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] mode;
    logic       sin;
    logic       busy;
    logic       done;
    logic       ready;
  } exp_t;

  exp_t     exp_q[$];
  int       vectors = 0;
  int       fails = 0;
  int       cyc = 0;
  int       acc_cnt = 0;
  int       acc_cyc = 0;
  int       n_ld = 0, n_rot = 0, n_fill = 0, n_done = 0;
  logic [W-1:0] lbits = '0;
  logic [W-1:0] q_reg = '0;

  // Downstream register driven by the sequencer outputs.
  always @(posedge clk) begin
    case (mode)
      2'b01:   q_reg <= {sIn, q_reg[W-1:1]};
      2'b10:   q_reg <= {q_reg[0], q_reg[W-1:1]};
      2'b11:   q_reg <= {sIn, sIn, q_reg[W-1:2]};
      default: q_reg <= q_reg;
    endcase
  end

  // Reference: a command expands into its list of per-cycle outputs; empty list means idle.
  always @(posedge clk or negedge Re) begin
    if (!Re) begin
      exp_q.delete();
    end else begin
      cyc++;
      if (exp_q.size() != 0) begin
        void'(exp_q.pop_front());
      end else if (cmd_valid) begin
        acc_cnt++;
        acc_cyc = cyc;
        case (cmd_op)
          2'b01: for (int i = 0; i < W; i++) exp_q.push_back('{2'b01, cmd_data[i], 1'b1, 1'b0, 1'b0});
          2'b10: for (int i = 0; i < ((cmd_cnt == 0) ? W : int'(cmd_cnt)); i++)
                   exp_q.push_back('{2'b10, 1'b0, 1'b1, 1'b0, 1'b0});
          2'b11: for (int i = 0; i < W / 2; i++) exp_q.push_back('{2'b11, cmd_data[0], 1'b1, 1'b0, 1'b0});
          default: ;
        endcase
        exp_q.push_back('{2'b00, 1'b0, 1'b1, 1'b1, 1'b0});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) e = exp_q[0];
    else e = '{2'b00, 1'b0, 1'b0, 1'b0, Re};
    vectors++;
    if ({mode, sIn, busy, done, cmd_ready} !== e) begin
      fails++;
      $display("FAIL cycle%0d outputs: got mode=%b sIn=%b busy=%b done=%b ready=%b, want mode=%b sIn=%b busy=%b done=%b ready=%b",
               cyc, mode, sIn, busy, done, cmd_ready, e.mode, e.sin, e.busy, e.done, e.ready);
    end
    if (mode == 2'b01) begin n_ld++; lbits = {sIn, lbits[W-1:1]}; end
    if (mode == 2'b10) n_rot++;
    if (mode == 2'b11) n_fill++;
    if (done === 1'b1) n_done++;
  end

  task automatic chk(input string name, input int act, input int want);
    vectors++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [W-1:0] d, input logic [2:0] c);
    int prev;
    prev = acc_cnt;
    cmd_op = op; cmd_data = d; cmd_cnt = c; cmd_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #2;
      if (acc_cnt != prev) break;
    end
    cmd_valid = 1'b0;
    chk("accept", acc_cnt - prev, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk); #2;
    end
    chk("idle_timeout", exp_q.size(), 0);
  endtask

  int b_ld, b_rot, b_fill, b_done, a1, a2;

  initial begin
    #1 Re = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_ready", cmd_ready, 0);
    chk("reset_mode", mode, 0);
    chk("reset_busy", busy, 0);
    Re = 1'b1;
    #1 chk("ready_after_reset", cmd_ready, 1);

    // LOAD 0xA5
    b_ld = n_ld; b_done = n_done;
    issue(2'b01, 8'hA5, 3'd0);
    wait_idle();
    chk("loadA5_cycles", n_ld - b_ld, 8);
    chk("loadA5_sin_seq", lbits, 8'hA5);
    chk("loadA5_q", q_reg, 8'hA5);
    chk("loadA5_done", n_done - b_done, 1);

    // LOAD 0x81, ROTATE 3, ROTATE 0
    issue(2'b01, 8'h81, 3'd0);
    wait_idle();
    b_rot = n_rot;
    issue(2'b10, 8'h00, 3'd3);
    wait_idle();
    chk("rot3_cycles", n_rot - b_rot, 3);
    chk("rot3_q", q_reg, 8'h30);
    b_rot = n_rot;
    issue(2'b10, 8'h00, 3'd0);
    wait_idle();
    chk("rot0_cycles", n_rot - b_rot, 8);
    chk("rot0_q", q_reg, 8'h30);

    // FILL
    issue(2'b11, 8'h00, 3'd0);
    wait_idle();
    chk("fill0_q", q_reg, 8'h00);
    b_fill = n_fill;
    issue(2'b11, 8'h01, 3'd0);
    wait_idle();
    chk("fill1_cycles", n_fill - b_fill, 4);
    chk("fill1_q", q_reg, 8'hFF);
    issue(2'b11, 8'hFE, 3'd0);
    wait_idle();
    chk("fill0b_q", q_reg, 8'h00);

    // Back-to-back LOAD 0x3C then NOP with valid held high
    b_done = n_done;
    a1 = acc_cnt;
    cmd_op = 2'b01; cmd_data = 8'h3C; cmd_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #2;
      if (acc_cnt != a1) break;
    end
    a1 = acc_cyc;
    cmd_op = 2'b00; cmd_data = 8'h00;
    b_ld = acc_cnt;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #2;
      if (acc_cnt != b_ld) break;
    end
    a2 = acc_cyc;
    cmd_valid = 1'b0;
    wait_idle();
    chk("b2b_pitch", a2 - a1, 10);
    chk("b2b_q", q_reg, 8'h3C);
    chk("b2b_done", n_done - b_done, 2);

    // Reset in cycle 4 of a LOAD
    issue(2'b01, 8'h55, 3'd0);
    repeat (3) @(posedge clk);
    #2;
    b_done = n_done;
    Re = 1'b0;
    #1;
    chk("midrst_mode", mode, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", cmd_ready, 0);
    repeat (3) @(posedge clk);
    #2 Re = 1'b1;
    chk("midrst_nodone", n_done - b_done, 0);
    issue(2'b01, 8'h0F, 3'd0);
    wait_idle();
    chk("after_rst_q", q_reg, 8'h0F);

    // Valid pulse while busy is ignored
    b_ld = n_ld; b_fill = n_fill; b_done = n_done;
    issue(2'b01, 8'h96, 3'd0);
    repeat (2) @(posedge clk);
    #2;
    cmd_op = 2'b11; cmd_data = 8'h01; cmd_valid = 1'b1;
    @(posedge clk);
    #2 cmd_valid = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);
    #2;
    chk("pulse_load_cycles", n_ld - b_ld, 8);
    chk("pulse_fill_cycles", n_fill - b_fill, 0);
    chk("pulse_done", n_done - b_done, 1);
    chk("pulse_q", q_reg, 8'h96);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/msrr8_cmd_sequencer.md
# msrr8_cmd_sequencer

Command sequencer that sits directly upstream of the team's 8-bit multi-mode shift/rotate register and drives its `mode` and `sIn` inputs. It accepts one command per valid/ready handshake: serial byte load, rotate-by-N, constant fill or no-op. It then issues the exact per-cycle mode/serial-bit sequence that makes the register reach the commanded value. A one-cycle `done` pulse marks completion, so a controller can chain register operations without counting cycles itself.

## Interface
- `W`, 8, bit width of the downstream register; sets load length (W cycles) and fill length (W/2 cycles); must be even, ≥ 2.
- `clk`  input  1  rising-edge clock, shared with the downstream register.
- `Re`  input  1  reset, asynchronous, active-low.
- `cmd_valid`  input  1  command present.
- `cmd_ready`  output  1  sequencer can accept a command.
- `cmd_op`  input  2  00 NOP, 01 LOAD, 10 ROTATE, 11 FILL.
- `cmd_data`  input  W  LOAD byte; bit 0 is the FILL value.
- `cmd_cnt`  input  $clog2(W)  ROTATE count; 0 means W.
- `mode`  output  2  to register `mode`: 00 hold, 01 shift-in, 10 rotate, 11 double shift-in.
- `sIn`  output  1  to register serial input.
- `busy`  output  1  a command is executing.
- `done`  output  1  one-cycle completion pulse.

## Operation
- States: IDLE, LOAD, ROT, FILL, DONE.
- `cmd_ready = (state==IDLE) && Re`. A command is accepted on a rising edge with `cmd_valid && cmd_ready`. `cmd_op`, `cmd_data` and `cmd_cnt` are latched on that edge.
- IDLE: `mode`=00, `sIn`=0.
- On accept:
  - NOP goes to DONE.
  - LOAD goes to LOAD with counter=W and data shift register = `cmd_data`.
  - ROTATE goes to ROT with counter = `cmd_cnt` (0 maps to W).
  - FILL goes to FILL with counter=W/2 and fill bit = `cmd_data[0]`.
- LOAD: `mode`=01 and `sIn`=data_sr[0], so the LSB goes first. Each edge shifts data_sr right by one and decrements the counter. When the counter reaches 1, the next state is DONE. After W downstream shifts the register holds `cmd_data`.
- ROT: `mode`=10, `sIn`=0, decrement per edge, exit to DONE after the last cycle. The register rotates right by `cmd_cnt` (mod W).
- FILL: `mode`=11, `sIn`=fill bit for W/2 cycles, then DONE. The register ends all-zeros or all-ones.
- DONE: `mode`=00, `done`=1 for exactly one cycle, then IDLE.
- `busy`=1 in LOAD/ROT/FILL/DONE, 0 in IDLE.
- `cmd_valid` while not ready is ignored. Upstream holds `cmd_*` stable until accepted.

## Timing
- All outputs are decoded from registered state and data only. There is no combinational path from `cmd_*` to `mode` or `sIn`.
- Reset (Re low, asynchronous): state IDLE, `mode`=00, `sIn`=0, `busy`=0, `done`=0, `cmd_ready`=0. Counter and data are cleared.
- First accept is possible on the first rising edge after Re rises.
- Latency, with accept at edge E0:
  - Active cycles run E0..E_N, where N = W, cnt or W/2. Downstream captures on E1..E_N.
  - `done`=1 in the cycle E_N..E_(N+1).
  - The next accept is possible at E_(N+2).
  - LOAD with W=8: 8 shift cycles, then 1 DONE cycle, giving a 10-edge command pitch.
- NOP: DONE in the cycle after accept, next accept two edges after the first.
- Reset mid-command: outputs return to hold (`mode`=00) immediately and asynchronously. The command is abandoned and no `done` is issued. Downstream contents are undefined.
- ROTATE with `cmd_cnt`=0 executes W cycles and leaves the register value unchanged.

## Test plan
- Reset, then LOAD 0xA5 → `mode`=01 for 8 cycles with `sIn` sequence 1,0,1,0,0,1,0,1; register Q=0xA5 at `done`; `done` high exactly 1 cycle.
- After loading 0x81, ROTATE cnt=3 → 3 cycles of `mode`=10, Q=0x30; then ROTATE cnt=0 → 8 cycles, Q still 0x30.
- FILL with `cmd_data[0]`=1 from Q=0x00 → 4 cycles `mode`=11, Q=0xFF. FILL with 0 from 0xFF → Q=0x00.
- Back-to-back LOAD 0x3C then NOP, with `cmd_valid` held high → second accept exactly at the edge after `done`. `cmd_ready` is 0 throughout LOAD. NOP's `done` follows one cycle after its accept.
- Re driven low at cycle 4 of a LOAD → `mode`=00, `busy`=0, `cmd_ready`=0 immediately, no `done` pulse. After release, LOAD 0x0F completes with Q=0x0F.
- `cmd_valid` pulsed for one cycle while busy → not accepted, no extra `done`, `mode` sequence unchanged.
